// File: rtl/cfg_lut_pkg.sv
// ============================================================================
// Module   : cfg_lut_pkg
// Brief    : Shared types, limits and helpers for the configurable LUT array.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cfg_lut_pkg;

    localparam int K_MAX  = 6;
    localparam int CH_MAX = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Total number of serial configuration bits for the whole array.
    function automatic int cfg_len(input int k, input int ch);
        return ch << k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_lut_array_lut_cell.sv
// ============================================================================
// Module   : lut_cell
// Brief    : One K-input lookup table with optional output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lut_cell
    import cfg_lut_pkg::*;
#(
    parameter int K       = 4,
    parameter int REG_OUT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2**K-1:0]   lut_table,
    input  logic [K-1:0]      addr,
    output logic              out
);

    logic w_lookup;

    assign w_lookup = lut_table[addr];

    generate
        if (REG_OUT != 0) begin : g_reg
            logic r_out;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_out <= 1'b0;
                end else begin
                    r_out <= w_lookup;
                end
            end

            assign out = r_out;
        end else begin : g_comb
            assign out = w_lookup;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/cfg_lut_array.sv
// ============================================================================
// Module   : cfg_lut_array
// Brief    : Array of run-time reprogrammable LUTs with double-buffered tables.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cfg_lut_array
    import cfg_lut_pkg::*;
#(
    parameter int                              K        = 4,
    parameter int                              CHANNELS = 2,
    parameter int                              REG_OUT  = 1,
    parameter logic [CHANNELS*(2**K)-1:0]      INIT     = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic                    cfg_valid,
    input  logic                    cfg_bit,
    output logic                    cfg_ready,
    output logic                    cfg_done,
    output logic                    busy,
    input  logic [CHANNELS*K-1:0]   lut_in,
    output logic [CHANNELS-1:0]     lut_out,
    output logic                    out_valid
);

    localparam int C_TBL     = 2**K;
    localparam int C_CFG_LEN = cfg_len(K, CHANNELS);
    localparam int C_CW      = $clog2(C_CFG_LEN + 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [C_CFG_LEN-1:0]   r_shadow;
    logic [C_CFG_LEN-1:0]   r_active;
    logic [C_CW-1:0]        r_count;
    logic                   r_out_valid;
    logic                   w_accept;
    logic                   w_last_bit;

    assign w_accept   = (r_state == LOAD) && cfg_valid && !cfg_start;
    assign w_last_bit = (r_count == C_CW'(C_CFG_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cfg_ready    = 1'b0;
        cfg_done     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (w_accept && w_last_bit) begin
                    w_next_state = COMMIT;
                end
            end
            COMMIT: begin
                cfg_done     = 1'b1;
                busy         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // A restart in LOAD wins over a bit presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= INIT;
            r_count  <= '0;
        end else begin
            if (cfg_start && (r_state != COMMIT)) begin
                r_count <= '0;
            end else if (w_accept) begin
                for (int j = 0; j < C_CFG_LEN; j++) begin
                    if (r_count == C_CW'(j)) begin
                        r_shadow[j] <= cfg_bit;
                    end
                end
                r_count <= r_count + C_CW'(1);
            end
            if (r_state == COMMIT) begin
                r_active <= r_shadow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            lut_cell #(
                .K       (K),
                .REG_OUT (REG_OUT)
            ) u_cell (
                .clk       (clk),
                .rst_n     (rst_n),
                .lut_table (r_active[c*C_TBL +: C_TBL]),
                .addr      (lut_in[c*K +: K]),
                .out       (lut_out[c])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cfg_lut_array.sv
// ============================================================================
// Module   : tb_cfg_lut_array
// Brief    : Scoreboard bench for cfg_lut_array (K=4, CHANNELS=2, REG_OUT=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cfg_lut_array;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit   = 1'b0;
    logic [7:0] lut_in    = 8'h00;
    logic       cfg_ready;
    logic       cfg_done;
    logic       busy;
    logic       out_valid;
    logic [1:0] lut_out;

    // Observed vector: {lut_out[1], lut_out[0], cfg_done, cfg_ready, busy, out_valid}
    localparam logic [5:0] M_LUT = 6'b110000;
    localparam logic [5:0] M_ST  = 6'b001110;
    localparam logic [5:0] M_ALL = 6'b111111;
    localparam logic [5:0] V_LOAD   = 6'b000110;
    localparam logic [5:0] V_COMMIT = 6'b001010;
    localparam logic [31:0] T2 = 32'h8000_FF5F;

    typedef struct {
        string      name;
        logic [5:0] mask;
        logic [5:0] val;
        int         done_exp;
    } item_t;

    item_t exp_q[$];
    int    passed   = 0;
    int    total    = 0;
    int    done_cnt = 0;

    cfg_lut_array #(
        .K        (4),
        .CHANNELS (2),
        .REG_OUT  (1),
        .INIT     (32'h0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .busy      (busy),
        .lut_in    (lut_in),
        .lut_out   (lut_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        item_t      it;
        logic [5:0] act;
        if (cfg_done === 1'b1) done_cnt++;
        if (exp_q.size() > 0) begin
            it  = exp_q.pop_front();
            act = {lut_out, cfg_done, cfg_ready, busy, out_valid};
            total++;
            if ((act & it.mask) === (it.val & it.mask)) passed++;
            else $display("FAIL %s: got %b want %b (mask %b)", it.name, act, it.val, it.mask);
            if (it.done_exp >= 0) begin
                total++;
                if (done_cnt == it.done_exp) passed++;
                else $display("FAIL %s done-count: got %0d want %0d", it.name, done_cnt, it.done_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic s, input logic v, input logic b, input logic [7:0] li);
        cfg_start = s;
        cfg_valid = v;
        cfg_bit   = b;
        lut_in    = li;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string n, input logic [5:0] m, input logic [5:0] v, input int d);
        item_t it;
        it.name     = n;
        it.mask     = m;
        it.val      = v;
        it.done_exp = d;
        exp_q.push_back(it);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic look(input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] e, input string n);
        drive(1'b0, 1'b0, 1'b0, {a1, a0});
        expect_v(n, M_LUT, {e, 4'b0000}, -1);
        nxt();
    endtask

    task automatic start_load(input string n);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        expect_v(n, M_ST, V_LOAD, -1);
        nxt();
    endtask

    // Shifts 32 bits LSB-first; with gaps, valid follows the 1-0-0-1 pattern.
    task automatic load32(input logic [31:0] d, input bit gaps, input int done_after, input string n);
        int   j = 0;
        int   c = 0;
        logic v;
        logic b;
        while (j < 32) begin
            v = gaps ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            b = d[j];
            drive(1'b0, v, b, 8'h00);
            if (v) j++;
            if (j < 32) expect_v({n, " load"}, M_ST, V_LOAD, -1);
            else        expect_v({n, " commit"}, M_ST, V_COMMIT, done_after);
            nxt();
            c++;
        end
    endtask

    task automatic check_t2_table(input string n);
        logic [3:0] a0s [8] = '{4'd0, 4'd9, 4'd10, 4'd11, 4'd1, 4'd4, 4'd5, 4'd7};
        logic [3:0] a1s [8] = '{4'd15, 4'd0, 4'd14, 4'd15, 4'd7, 4'd3, 4'd15, 4'd0};
        logic [1:0] es  [8] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 8; i++) begin
            look(a0s[i], a1s[i], es[i], $sformatf("%s lookup %0d", n, i));
        end
    endtask

    initial begin
        nxt();
        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'hFF);
            expect_v("reset", M_ALL, 6'b000000, -1);
            nxt();
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        expect_v("release", M_ALL, 6'b000001, 0);
        nxt();
        look(4'd15, 4'd15, 2'b00, "init a");
        look(4'd5,  4'd9,  2'b00, "init b");

        // Gapless load of ch0=FF5F, ch1=8000
        start_load("t2 start");
        load32(T2, 1'b0, 1, "t2");
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        expect_v("t2 idle", M_ST, 6'b000000, 1);
        nxt();
        check_t2_table("t2");

        // Partial all-zero load must not disturb the active table
        start_load("t4 start");
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            nxt();
        end
        look(4'd5, 4'd15, 2'b10, "t4 shadow a");
        look(4'd0, 4'd0,  2'b01, "t4 shadow b");
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        expect_v("t4 busy", M_ST, V_LOAD, 1);
        nxt();

        // Restart with a simultaneous bit at position 20
        for (int i = 10; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            nxt();
        end
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        expect_v("t5 restart", M_ST, V_LOAD, -1);
        nxt();
        load32(32'hFFFF_FFFF, 1'b0, 2, "t5");
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        expect_v("t5 idle", M_ST, 6'b000000, 2);
        nxt();
        look(4'd3, 4'd12, 2'b11, "t5 ones a");
        look(4'd5, 4'd7,  2'b11, "t5 ones b");

        // Reset during a load at bit 15
        start_load("t6 start");
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            nxt();
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            expect_v("t6 in reset", M_ALL, 6'b000000, 2);
            nxt();
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        expect_v("t6 released", 6'b001111, 6'b000001, 2);
        nxt();
        look(4'd3,  4'd12, 2'b00, "t6 init a");
        look(4'd15, 4'd15, 2'b00, "t6 init b");

        // Backpressured load; cfg_start during COMMIT must be ignored
        start_load("t3 start");
        load32(T2, 1'b1, 3, "t3");
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        expect_v("t3 start in commit", M_ST, 6'b000000, 3);
        nxt();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        expect_v("t3 stays idle", M_ST, 6'b000000, 3);
        nxt();
        check_t2_table("t3");

        nxt();
        nxt();
        #1;
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
